// File: rtl/mips_mc_controller.sv
// rtl/mips_mc_controller.sv - multicycle MIPS control FSM driving datapath enables and muxes
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   op, funct, zero      IR opcode/funct fields and ALU zero flag
//   memready             shared memory port completes its access this cycle
//   iord .. pcen         datapath selects and enables
//   illegal              one-cycle pulse on an undecodable opcode or funct
//   state                current state encoding for debug
module mips_mc_controller #(
  parameter bit ENABLE_ADDI = 1'b1,
  parameter bit ENABLE_BNE  = 1'b1,
  parameter bit ENABLE_JUMP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       pcen,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    BNEEX   = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    JEX     = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  state_t     cur;
  logic       op_ok;
  logic       funct_ok;
  logic [2:0] funct_alu;

  // Disabled optional opcodes fall out of the legal set entirely.
  always_comb begin
    op_ok = (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_BEQ) ||
            (ENABLE_BNE  && (op == OP_BNE))  ||
            (ENABLE_ADDI && (op == OP_ADDI)) ||
            (ENABLE_JUMP && (op == OP_J));
  end

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = 3'b010;
      6'b100010: funct_alu = 3'b110;
      6'b100100: funct_alu = 3'b000;
      6'b100101: funct_alu = 3'b001;
      6'b101010: funct_alu = 3'b111;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= FETCH;
    end else begin
      case (cur)
        FETCH:   if (memready) cur <= DECODE;
        DECODE: begin
          if ((op == OP_LW) || (op == OP_SW))  cur <= MEMADR;
          else if (op == OP_R)                 cur <= RTYPEEX;
          else if (op == OP_BEQ)               cur <= BEQEX;
          else if (ENABLE_BNE  && op == OP_BNE)  cur <= BNEEX;
          else if (ENABLE_ADDI && op == OP_ADDI) cur <= ADDIEX;
          else if (ENABLE_JUMP && op == OP_J)    cur <= JEX;
          else                                 cur <= FETCH;
        end
        MEMADR:  cur <= (op == OP_SW) ? MEMWR : MEMRD;
        MEMRD:   if (memready) cur <= MEMWB;
        MEMWB:   cur <= FETCH;
        MEMWR:   if (memready) cur <= FETCH;
        RTYPEEX: cur <= funct_ok ? RTYPEWB : FETCH;
        RTYPEWB: cur <= FETCH;
        BEQEX:   cur <= FETCH;
        BNEEX:   cur <= FETCH;
        ADDIEX:  cur <= ADDIWB;
        ADDIWB:  cur <= FETCH;
        JEX:     cur <= FETCH;
        default: cur <= FETCH;
      endcase
    end
  end

  assign state = cur;

  // Outputs are a function of state; only pcen/irwrite look at memready/zero directly.
  // Side-effecting strobes are masked by reset in the same cycle so an aborted
  // store cannot keep writing.
  always_comb begin
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;
    pcen       = 1'b0;
    illegal    = 1'b0;
    case (cur)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = memready;
        pcen    = memready;
      end
      DECODE: begin
        alusrcb = 2'b11;
        illegal = ~op_ok;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:   iord = 1'b1;
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
        illegal    = ~funct_ok;
      end
      RTYPEWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      BEQEX, BNEEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        pcen       = (cur == BEQEX) ? zero : ~zero;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB:  regwrite = 1'b1;
      JEX: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      memwrite = 1'b0;
      regwrite = 1'b0;
      irwrite  = 1'b0;
      pcen     = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb/tb_mips_mc_controller.sv - directed self-checking bench for mips_mc_controller
module tb_mips_mc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       memready = 1'b0;

  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  logic       iord_nj, memwrite_nj, irwrite_nj, regdst_nj, memtoreg_nj, regwrite_nj;
  logic       alusrca_nj, pcen_nj, illegal_nj;
  logic [1:0] alusrcb_nj, pcsrc_nj;
  logic [2:0] alucontrol_nj;
  logic [3:0] state_nj;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .pcen(pcen), .illegal(illegal), .state(state)
  );

  mips_mc_controller #(.ENABLE_JUMP(1'b0)) dut_nj (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .iord(iord_nj), .memwrite(memwrite_nj), .irwrite(irwrite_nj), .regdst(regdst_nj),
    .memtoreg(memtoreg_nj), .regwrite(regwrite_nj), .alusrca(alusrca_nj),
    .alusrcb(alusrcb_nj), .pcsrc(pcsrc_nj), .alucontrol(alucontrol_nj), .pcen(pcen_nj),
    .illegal(illegal_nj), .state(state_nj)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    memready = 1'b1;
    zero = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    memready = 1'b1;
    op = 6'd0;
    cyc();
    cyc();
    #1;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++;
    if ({irwrite, pcen} !== 2'b00) begin errors++; $display("FAIL reset_enables got %b exp 00", {irwrite, pcen}); end
    reset = 1'b0;
    #1;
    checks++;
    if ({irwrite, pcen} !== 2'b11) begin errors++; $display("FAIL first_fetch_enables got %b exp 11", {irwrite, pcen}); end
    cyc();
    #1;
    checks++;
    if (state !== 4'd1) begin errors++; $display("FAIL first_decode got %0d exp 1", state); end
    checks++;
    if ({irwrite, pcen} !== 2'b00) begin errors++; $display("FAIL decode_enables got %b exp 00", {irwrite, pcen}); end
  endtask

  task automatic test_lw();
    logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    logic       exp_wb;
    do_reset();
    op = 6'b100011;
    for (int i = 0; i < 5; i++) begin
      #1;
      exp_wb = (i == 4);
      checks++;
      if (state !== exp_st[i]) begin errors++; $display("FAIL lw_state c%0d got %0d exp %0d", i, state, exp_st[i]); end
      checks++;
      if ({regwrite, memtoreg} !== {exp_wb, exp_wb}) begin
        errors++; $display("FAIL lw_wb c%0d got %b exp %b", i, {regwrite, memtoreg}, {exp_wb, exp_wb});
      end
      if (i == 3) begin
        checks++;
        if (iord !== 1'b1) begin errors++; $display("FAIL lw_iord got %b exp 1", iord); end
      end
      cyc();
    end
    #1;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL lw_done got %0d exp 0", state); end
  endtask

  task automatic test_sw_wait();
    logic [3:0] exp_st [7] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
    logic       mr     [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp_mw;
    do_reset();
    op = 6'b101011;
    for (int i = 0; i < 7; i++) begin
      memready = mr[i];
      #1;
      exp_mw = (i >= 3);
      checks++;
      if (state !== exp_st[i]) begin errors++; $display("FAIL sw_state c%0d got %0d exp %0d", i, state, exp_st[i]); end
      checks++;
      if (memwrite !== exp_mw) begin errors++; $display("FAIL sw_memwrite c%0d got %b exp %b", i, memwrite, exp_mw); end
      if (i >= 3) begin
        checks++;
        if ({pcen, regwrite, iord} !== 3'b001) begin
          errors++; $display("FAIL sw_wait_outs c%0d got %b exp 001", i, {pcen, regwrite, iord});
        end
      end
      cyc();
    end
    memready = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL sw_done got %0d exp 0", state); end
  endtask

  task automatic test_reset_abort();
    do_reset();
    op = 6'b101011;
    cyc(); cyc(); cyc();
    memready = 1'b0;
    #1;
    checks++;
    if (memwrite !== 1'b1) begin errors++; $display("FAIL abort_pre got %b exp 1", memwrite); end
    reset = 1'b1;
    #1;
    checks++;
    if ({memwrite, state} !== {1'b0, 4'd5}) begin
      errors++; $display("FAIL abort_drop got %b/%0d exp 0/5", memwrite, state);
    end
    cyc();
    reset = 1'b0;
    memready = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL abort_state got %0d exp 0", state); end
  endtask

  task automatic test_rtype();
    do_reset();
    op = 6'b000000;
    funct = 6'b100010;
    cyc(); cyc();
    #1;
    checks++;
    if ({state, alucontrol, alusrca, alusrcb, illegal} !== {4'd6, 3'b110, 1'b1, 2'b00, 1'b0}) begin
      errors++; $display("FAIL rtype_ex got st%0d alu%b a%b b%b il%b exp st6 alu110 a1 b00 il0",
                        state, alucontrol, alusrca, alusrcb, illegal);
    end
    cyc();
    #1;
    checks++;
    if ({state, regdst, regwrite, memtoreg} !== {4'd7, 3'b110}) begin
      errors++; $display("FAIL rtype_wb got st%0d %b exp st7 110", state, {regdst, regwrite, memtoreg});
    end
    cyc();
    #1;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL rtype_done got %0d exp 0", state); end
    // bad funct
    do_reset();
    funct = 6'b000000;
    cyc();
    #1;
    checks++;
    if (illegal !== 1'b0) begin errors++; $display("FAIL badfunct_decode got %b exp 0", illegal); end
    cyc();
    #1;
    checks++;
    if ({state, illegal, alucontrol, regwrite} !== {4'd6, 1'b1, 3'b010, 1'b0}) begin
      errors++; $display("FAIL badfunct_ex got st%0d il%b alu%b rw%b exp st6 il1 alu010 rw0",
                        state, illegal, alucontrol, regwrite);
    end
    cyc();
    #1;
    checks++;
    if ({state, illegal, regwrite} !== {4'd0, 2'b00}) begin
      errors++; $display("FAIL badfunct_done got st%0d il%b rw%b exp st0 il0 rw0", state, illegal, regwrite);
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops [4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
    logic       zs  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] est [4] = '{4'd8, 4'd8, 4'd9, 4'd9};
    logic       epc [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      do_reset();
      op = ops[k];
      zero = zs[k];
      cyc(); cyc();
      #1;
      checks++;
      if ({state, pcen, pcsrc, alucontrol} !== {est[k], epc[k], 2'b01, 3'b110}) begin
        errors++; $display("FAIL branch%0d got st%0d pcen%b pcsrc%b alu%b exp st%0d pcen%b pcsrc01 alu110",
                          k, state, pcen, pcsrc, alucontrol, est[k], epc[k]);
      end
      cyc();
      #1;
      checks++;
      if (state !== 4'd0) begin errors++; $display("FAIL branch%0d_done got %0d exp 0", k, state); end
    end
  endtask

  task automatic test_jump();
    do_reset();
    op = 6'b000010;
    cyc();
    #1;
    checks++;
    if ({illegal, illegal_nj} !== 2'b01) begin
      errors++; $display("FAIL jump_decode_illegal got %b exp 01", {illegal, illegal_nj});
    end
    memready = 1'b0;
    cyc();
    #1;
    checks++;
    if ({state, pcsrc, pcen} !== {4'd12, 2'b10, 1'b1}) begin
      errors++; $display("FAIL jump_ex got st%0d pcsrc%b pcen%b exp st12 pcsrc10 pcen1", state, pcsrc, pcen);
    end
    checks++;
    if ({state_nj, pcen_nj, illegal_nj} !== {4'd0, 2'b00}) begin
      errors++; $display("FAIL nojump_fetch got st%0d pcen%b il%b exp st0 pcen0 il0", state_nj, pcen_nj, illegal_nj);
    end
    memready = 1'b1;
    cyc();
    #1;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL jump_done got %0d exp 0", state); end
  endtask

  task automatic test_illegal_op();
    do_reset();
    op = 6'b111111;
    cyc();
    #1;
    checks++;
    if ({state, illegal} !== {4'd1, 1'b1}) begin
      errors++; $display("FAIL badop_decode got st%0d il%b exp st1 il1", state, illegal);
    end
    cyc();
    #1;
    checks++;
    if ({state, illegal} !== {4'd0, 1'b0}) begin
      errors++; $display("FAIL badop_done got st%0d il%b exp st0 il0", state, illegal);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_reset_abort();
    test_rtype();
    test_branch();
    test_jump();
    test_illegal_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
